video_timing_detect: RTL

VIDEO_TIMING_DETECT -- requirements
Module: video_timing_detect

---
 rtl/video_timing_detect.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/video_timing_detect.sv
// Recovers line/frame timing from raw sync and blank inputs and locks once it is stable.
// Optional automatic sync-polarity detection is enabled by defining VIDEO_TIMING_DETECT_POL_AUTO_EN.
module video_timing_detect #(
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce_pix,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       hbl,
    input  logic       vbl,
    output logic [8:0] hc,
    output logic [8:0] vc,
    output logic [8:0] htotal,
    output logic [8:0] vtotal,
    output logic [8:0] hactive,
    output logic [8:0] vactive,
    output logic       locked,
    output logic       frame_start,
    output logic       hs_neg,
    output logic       vs_neg
);

    // state    | meaning
    // UNLOCKED | waiting for the first v-edge; that frame's measurement is discarded
    // ACQUIRE  | holding a candidate and counting consecutive matching frames
    // LOCKED   | totals published; any mismatch or counter saturation drops lock
    typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

    localparam logic [8:0] CNT_MAX = 9'd511;
    localparam logic [2:0] LOCK_N  = LOCK_FRAMES[2:0];

    state_t     state, state_next;
    logic       hs_prev, vs_prev, primed;
    logic       hs_pol, vs_pol, h_edge, v_edge;
    logic [8:0] cnt_h, cnt_v, act_h, act_v, meas_h, hact_cand;
    logic [8:0] cur_h, hact_next;
    logic [8:0] cand_h, cand_v, cand_h_next, cand_v_next;
    logic       cand_valid, cand_valid_next;
    logic [2:0] match, match_next, match_inc;
    logic       load, sat, pol_change;

`ifdef VIDEO_TIMING_DETECT_POL_AUTO_EN
    logic [9:0]  pol_cnt;
    logic [10:0] hs_high, vs_high, hs_total, vs_total;
    logic        hs_neg_next, vs_neg_next;

    assign hs_total    = hs_high + {10'd0, hsync};
    assign vs_total    = vs_high + {10'd0, vsync};
    assign hs_neg_next = (hs_total > 11'd512);
    assign vs_neg_next = (vs_total > 11'd512);
    assign pol_change  = ce_pix && (pol_cnt == 10'd1023) &&
                         ((hs_neg_next != hs_neg) || (vs_neg_next != vs_neg));

    always_ff @(posedge clk) begin
        if (reset) begin
            pol_cnt <= '0;
            hs_high <= '0;
            vs_high <= '0;
            hs_neg  <= 1'b0;
            vs_neg  <= 1'b0;
        end else if (ce_pix) begin
            pol_cnt <= pol_cnt + 10'd1;
            if (pol_cnt == 10'd1023) begin
                hs_neg  <= hs_neg_next;
                vs_neg  <= vs_neg_next;
                hs_high <= '0;
                vs_high <= '0;
            end else begin
                hs_high <= hs_total;
                vs_high <= vs_total;
            end
        end
    end
`else
    assign hs_neg     = 1'b0;
    assign vs_neg     = 1'b0;
    assign pol_change = 1'b0;
`endif

    assign hs_pol = hsync ^ hs_neg;
    assign vs_pol = vsync ^ vs_neg;
    // primed suppresses a false edge against the reset value of the previous sample
    assign h_edge = ce_pix && primed && hs_pol && !hs_prev;
    assign v_edge = ce_pix && primed && vs_pol && !vs_prev;

    assign cur_h     = h_edge ? cnt_h : meas_h;
    assign hact_next = (h_edge && !vbl) ? act_h : hact_cand;
    assign sat       = ce_pix && ((cnt_h == CNT_MAX) || (cnt_v == CNT_MAX));
    assign match_inc = match + 3'd1;
    assign locked    = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (reset) begin
            primed      <= 1'b0;
            hs_prev     <= 1'b0;
            vs_prev     <= 1'b0;
            cnt_h       <= '0;
            cnt_v       <= '0;
            act_h       <= '0;
            act_v       <= '0;
            meas_h      <= '0;
            hact_cand   <= '0;
            hc          <= '0;
            vc          <= '0;
            frame_start <= 1'b0;
        end else begin
            hc          <= cnt_h;
            vc          <= cnt_v;
            frame_start <= v_edge;
            if (ce_pix) begin
                primed  <= 1'b1;
                hs_prev <= hs_pol;
                vs_prev <= vs_pol;
                if (h_edge) begin
                    meas_h <= cnt_h;
                    cnt_h  <= '0;
                    act_h  <= '0;
                    if (!vbl)
                        hact_cand <= act_h;
                end else begin
                    if (cnt_h != CNT_MAX)
                        cnt_h <= cnt_h + 9'd1;
                    if (!hbl && act_h != CNT_MAX)
                        act_h <= act_h + 9'd1;
                end
                // a v-edge wins over a coincident h-edge so the new frame starts at line 0
                if (v_edge) begin
                    cnt_v <= '0;
                    act_v <= '0;
                end else if (h_edge) begin
                    if (cnt_v != CNT_MAX)
                        cnt_v <= cnt_v + 9'd1;
                    if (!vbl && act_v != CNT_MAX)
                        act_v <= act_v + 9'd1;
                end
            end
        end
    end

    always_comb begin
        state_next      = state;
        cand_h_next     = cand_h;
        cand_v_next     = cand_v;
        cand_valid_next = cand_valid;
        match_next      = match;
        load            = 1'b0;
        case (state)
            UNLOCKED: begin
                if (v_edge) begin
                    state_next      = ACQUIRE;
                    cand_valid_next = 1'b0;
                    match_next      = '0;
                end
            end
            ACQUIRE: begin
                if (v_edge) begin
                    if (!cand_valid || cur_h != cand_h || cnt_v != cand_v) begin
                        cand_h_next     = cur_h;
                        cand_v_next     = cnt_v;
                        cand_valid_next = 1'b1;
                        match_next      = '0;
                    end else begin
                        match_next = match_inc;
                        if (match_inc >= LOCK_N) begin
                            state_next = LOCKED;
                            load       = 1'b1;
                        end
                    end
                end else if (h_edge && cand_valid && cnt_h != cand_h) begin
                    cand_valid_next = 1'b0;
                    match_next      = '0;
                end
            end
            LOCKED: begin
                if ((h_edge && cnt_h != htotal) || (v_edge && cnt_v != vtotal) || sat)
                    state_next = UNLOCKED;
            end
            default: state_next = UNLOCKED;
        endcase
        if (pol_change)
            state_next = UNLOCKED;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= UNLOCKED;
            cand_h     <= '0;
            cand_v     <= '0;
            cand_valid <= 1'b0;
            match      <= '0;
            htotal     <= '0;
            vtotal     <= '0;
            hactive    <= '0;
            vactive    <= '0;
        end else begin
            state      <= state_next;
            cand_h     <= cand_h_next;
            cand_v     <= cand_v_next;
            cand_valid <= cand_valid_next;
            match      <= match_next;
            if (load) begin
                htotal  <= cand_h;
                vtotal  <= cand_v;
                hactive <= hact_next;
                vactive <= act_v;
            end
        end
    end

endmodule
